// File: rtl/camera_capture.sv
// OV7670-style capture front end: pairs RGB444 bytes from the camera bus into
// RGB332 pixels and produces linear frame-buffer writes plus frame/error status.
module camera_capture #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_WIDTH    = 15
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VSYNC,
    input  logic                  HREF,
    input  logic [7:0]            D,
    output logic [ADDR_WIDTH-1:0] W_ADDR,
    output logic [7:0]            W_DATA,
    output logic                  W_EN,
    output logic                  FRAME_DONE,
    output logic [7:0]            FRAME_COUNT,
    output logic [7:0]            LINE_COUNT,
    output logic                  PROTO_ERR
);

    localparam logic [7:0] X_LIMIT = 8'(SCREEN_WIDTH);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_HEIGHT);
    localparam logic [7:0] SAT_MAX = 8'hFF;

    typedef enum logic {
        SYNC_WAIT = 1'b0,
        FRAME     = 1'b1
    } state_t;

    state_t                state;
    logic                  prev_vsync;
    logic                  prev_href;
    logic                  byte_phase;
    logic [7:0]            first_byte;
    logic [7:0]            x;
    logic [7:0]            y;
    logic [7:0]            line_cnt;

    logic                  vsync_rise;
    logic                  href_fall;
    logic                  pixel_fits;
    logic [ADDR_WIDTH-1:0] pixel_addr;
    logic [7:0]            pixel_rgb332;

    always_comb begin
        vsync_rise   = VSYNC && !prev_vsync;
        href_fall    = !HREF && prev_href;
        pixel_fits   = (x < X_LIMIT) && (y < Y_LIMIT);
        pixel_addr   = ADDR_WIDTH'(x) + ADDR_WIDTH'(y) * ADDR_WIDTH'(SCREEN_WIDTH);
        // Keep the top bits of each RGB444 channel: R[3:1] from the first byte, G[3:1] and B[3:2] from the second.
        pixel_rgb332 = {first_byte[3:1], D[7:5], D[3:2]};
    end

    // NOTE: every register here is written with <= so all updates use the values sampled at the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= SYNC_WAIT;
            prev_vsync  <= 1'b0;
            prev_href   <= 1'b0;
            byte_phase  <= 1'b0;
            first_byte  <= 8'd0;
            x           <= 8'd0;
            y           <= 8'd0;
            line_cnt    <= 8'd0;
            W_ADDR      <= '0;
            W_DATA      <= 8'd0;
            W_EN        <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_COUNT <= 8'd0;
            LINE_COUNT  <= 8'd0;
            PROTO_ERR   <= 1'b0;
        end else begin
            prev_vsync <= VSYNC;
            prev_href  <= HREF;
            W_EN       <= 1'b0;
            FRAME_DONE <= 1'b0;

            if (vsync_rise) begin
                // Frame start wins over anything else on the bus this cycle.
                x          <= 8'd0;
                y          <= 8'd0;
                byte_phase <= 1'b0;
                line_cnt   <= 8'd0;
                state      <= FRAME;
                if (state == FRAME) begin
                    FRAME_DONE  <= 1'b1;
                    FRAME_COUNT <= FRAME_COUNT + 8'd1;
                    LINE_COUNT  <= line_cnt;
                end
            end else if (state == FRAME) begin
                if (HREF) begin
                    if (!byte_phase) begin
                        first_byte <= D;
                        byte_phase <= 1'b1;
                    end else begin
                        W_DATA     <= pixel_rgb332;
                        W_ADDR     <= pixel_addr;
                        W_EN       <= pixel_fits;
                        byte_phase <= 1'b0;
                        if (x != SAT_MAX) begin
                            x <= x + 8'd1;
                        end
                        if (x >= X_LIMIT) begin
                            PROTO_ERR <= 1'b1;
                        end
                    end
                end else if (href_fall) begin
                    if (y != SAT_MAX) begin
                        y <= y + 8'd1;
                    end
                    if (line_cnt != SAT_MAX) begin
                        line_cnt <= line_cnt + 8'd1;
                    end
                    // An odd byte count or a line past the frame height is a bus error; the stray byte is dropped.
                    if (byte_phase || (line_cnt >= Y_LIMIT)) begin
                        PROTO_ERR <= 1'b1;
                    end
                    x          <= 8'd0;
                    byte_phase <= 1'b0;
                end else begin
                    x          <= 8'd0;
                    byte_phase <= 1'b0;
                end
            end
        end
    end

endmodule
